// File: rtl/uart_slave_pkg.sv
// Shared constants, register map and state types for the RIB UART slave.
// Imported by the interface, the receiver and the top.
package uart_slave_pkg;

    localparam int unsigned CPU_WIDTH      = 32;
    localparam int unsigned UART_SLAVE_IDX = 3;   // RIB slave 3, region 0x3xxx_xxxx

    localparam logic [15:0] UART_DEFAULT_DIV = 16'd434;

    localparam logic [7:0] UART_CTRL   = 8'h00;
    localparam logic [7:0] UART_STATUS = 8'h04;
    localparam logic [7:0] UART_BAUD   = 8'h08;
    localparam logic [7:0] UART_TXDATA = 8'h0C;
    localparam logic [7:0] UART_RXDATA = 8'h10;

    localparam int unsigned CTRL_TX_EN     = 0;
    localparam int unsigned CTRL_RX_EN     = 1;
    localparam int unsigned CTRL_RX_IRQ_EN = 2;

    localparam int unsigned STATUS_TX_BUSY      = 0;
    localparam int unsigned STATUS_RX_VALID     = 1;
    localparam int unsigned STATUS_RX_OVERRUN   = 2;
    localparam int unsigned STATUS_RX_FRAME_ERR = 3;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    // Divisors below 2 would leave no room for a mid-bit sample point.
    function automatic logic [15:0] eff_div(input logic [15:0] baud);
        return (baud < 16'd2) ? 16'd2 : baud;
    endfunction

endpackage

// File: rtl/uart_slave_if.sv
// RIB slave-side bus bundle: address, write data, write strobe and registered read data.
interface uart_slave_if;
    import uart_slave_pkg::*;

    logic [CPU_WIDTH-1:0] addr_i;
    logic [CPU_WIDTH-1:0] data_i;
    logic                 we_i;
    logic [CPU_WIDTH-1:0] data_o;

    modport master (output addr_i, output data_i, output we_i, input data_o);
    modport slave  (input addr_i, input data_i, input we_i, output data_o);

endinterface

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, falling-edge start detect and mid-bit sampling FSM.
// Emits the received byte with single-cycle valid / frame-error pulses.
module uart_rx
    import uart_slave_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    input  logic        rx_en,
    input  logic [15:0] div,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        rx_frame_err
);

    logic sync_q1, sync_q2, prev_q;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync_q1 <= rx_i;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign fall = prev_q & ~sync_q2;

    rx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RxIdle;
            cnt_q   <= '0;
            div_q   <= 16'd2;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        div_d        = div_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        rx_valid     = 1'b0;
        rx_frame_err = 1'b0;

        if (!rx_en) begin
            state_d = RxIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RxIdle: begin
                    cnt_d = '0;
                    if (fall) begin
                        state_d = RxStart;
                        div_d   = div;
                    end
                end
                RxStart: begin
                    // Half-bit check rejects glitches shorter than the start bit.
                    if (cnt_q == (div_q >> 1) - 16'd1) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = sync_q2 ? RxIdle : RxData;
                    end
                end
                RxData: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_d   = '0;
                        shift_d = {sync_q2, shift_q[7:1]};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = RxStop;
                        end
                    end
                end
                RxStop: begin
                    if (cnt_q == div_q - 16'd1) begin
                        cnt_d   = '0;
                        state_d = RxIdle;
                        if (sync_q2) begin
                            rx_valid = 1'b1;
                        end else begin
                            rx_frame_err = 1'b1;
                        end
                    end
                end
                default: state_d = RxIdle;
            endcase
        end
    end

    assign rx_byte = shift_q;

endmodule

// File: rtl/uart_slave.sv
// Memory-mapped 8N1 UART on RIB slave 3: register file, read mux, TX shifter and
// a uart_rx instance. Read data is registered, returned one cycle after the address.
module uart_slave
    import uart_slave_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = UART_DEFAULT_DIV,
    parameter int unsigned ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    uart_slave_if.slave bus,
    output logic        tx_o,
    input  logic        rx_i,
    output logic        irq_o
);

    localparam logic [ADDR_BITS-1:0] OffCtrl   = ADDR_BITS'(UART_CTRL);
    localparam logic [ADDR_BITS-1:0] OffStatus = ADDR_BITS'(UART_STATUS);
    localparam logic [ADDR_BITS-1:0] OffBaud   = ADDR_BITS'(UART_BAUD);
    localparam logic [ADDR_BITS-1:0] OffTxdata = ADDR_BITS'(UART_TXDATA);
    localparam logic [ADDR_BITS-1:0] OffRxdata = ADDR_BITS'(UART_RXDATA);

    logic [ADDR_BITS-1:0] off;
    logic sel_ctrl, sel_status, sel_baud, sel_txdata, sel_rxdata;
    logic wr_ctrl, wr_status, wr_baud, wr_txdata;
    logic unused_bits;

    assign off        = bus.addr_i[ADDR_BITS-1:0];
    assign sel_ctrl   = (off == OffCtrl);
    assign sel_status = (off == OffStatus);
    assign sel_baud   = (off == OffBaud);
    assign sel_txdata = (off == OffTxdata);
    assign sel_rxdata = (off == OffRxdata);

    assign wr_ctrl    = bus.we_i & sel_ctrl;
    assign wr_status  = bus.we_i & sel_status;
    assign wr_baud    = bus.we_i & sel_baud;
    assign wr_txdata  = bus.we_i & sel_txdata;

    // Upper address bits alias the map; upper data bits have no backing storage.
    assign unused_bits = ^{bus.addr_i[CPU_WIDTH-1:ADDR_BITS], bus.data_i[CPU_WIDTH-1:16]};

    logic [2:0]           ctrl_q;
    logic [15:0]          baud_q;
    logic [7:0]           rx_data_q;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_overrun_q, rx_overrun_d;
    logic                 rx_frame_err_q, rx_frame_err_d;
    logic [CPU_WIDTH-1:0] rdata_q, rdata_d;
    logic                 tx_busy;

    logic [7:0] rx_byte;
    logic       rx_done, rx_ferr;

    uart_rx u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx_i),
        .rx_en        (ctrl_q[CTRL_RX_EN]),
        .div          (eff_div(baud_q)),
        .rx_byte      (rx_byte),
        .rx_valid     (rx_done),
        .rx_frame_err (rx_ferr)
    );

    // W1C first, hardware set afterwards so a same-cycle event is never lost.
    always_comb begin
        rx_valid_d     = rx_valid_q;
        rx_overrun_d   = rx_overrun_q;
        rx_frame_err_d = rx_frame_err_q;
        if (wr_status) begin
            if (bus.data_i[STATUS_RX_VALID])     rx_valid_d     = 1'b0;
            if (bus.data_i[STATUS_RX_OVERRUN])   rx_overrun_d   = 1'b0;
            if (bus.data_i[STATUS_RX_FRAME_ERR]) rx_frame_err_d = 1'b0;
        end
        if (rx_done) begin
            rx_valid_d = 1'b1;
            if (rx_valid_q) rx_overrun_d = 1'b1;
        end
        if (rx_ferr) rx_frame_err_d = 1'b1;
    end

    always_comb begin
        rdata_d = '0;
        if (sel_ctrl) begin
            rdata_d[2:0] = ctrl_q;
        end else if (sel_status) begin
            rdata_d[3:0] = {rx_frame_err_q, rx_overrun_q, rx_valid_q, tx_busy};
        end else if (sel_baud) begin
            rdata_d[15:0] = baud_q;
        end else if (sel_rxdata) begin
            rdata_d[7:0] = rx_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q         <= '0;
            baud_q         <= DEFAULT_DIV;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
            rdata_q        <= '0;
        end else begin
            if (wr_ctrl) ctrl_q <= bus.data_i[2:0];
            if (wr_baud) baud_q <= bus.data_i[15:0];
            if (rx_done) rx_data_q <= rx_byte;
            rx_valid_q     <= rx_valid_d;
            rx_overrun_q   <= rx_overrun_d;
            rx_frame_err_q <= rx_frame_err_d;
            rdata_q        <= rdata_d;
        end
    end

    assign bus.data_o = rdata_q;
    assign irq_o      = rx_valid_q & ctrl_q[CTRL_RX_IRQ_EN];

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_start;

    assign tx_busy  = (tx_state_q != TxIdle);
    assign tx_start = wr_txdata & ctrl_q[CTRL_TX_EN] & ~tx_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'd2;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_o       = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_state_d = TxStart;
                    tx_div_d   = eff_div(baud_q);
                    tx_shift_d = bus.data_i[7:0];
                end
            end
            TxStart: begin
                tx_o = 1'b0;
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end
            end
            TxData: begin
                tx_o = tx_shift_q[0];
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                end
            end
            TxStop: begin
                if (tx_cnt_q == tx_div_q - 16'd1) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TxIdle;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

endmodule

// File: tb/tb_uart_slave.sv
// Randomized self-checking bench for uart_slave against a frame-level reference model.
module tb_uart_slave;
    import uart_slave_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rx_line;
    logic tx_line;
    logic irq;

    always #5 clk = ~clk;

    uart_slave_if bus ();

    uart_slave dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .tx_o  (tx_line),
        .rx_i  (rx_line),
        .irq_o (irq)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: what software should see.
    logic [15:0] m_baud;
    logic [2:0]  m_ctrl;
    logic        m_valid, m_overrun, m_ferr;
    logic [7:0]  m_rxdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.addr_i = a;
        bus.data_i = d;
        bus.we_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.we_i   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a;
        bus.we_i   = 1'b0;
        @(posedge clk);
        #1;
        d = bus.data_o;
    endtask

    function automatic int div_of(input logic [15:0] b);
        return (b < 16'd2) ? 2 : int'(b);
    endfunction

    task automatic model_frame(input logic [7:0] b, input logic good);
        if (good) begin
            if (m_valid) m_overrun = 1'b1;
            m_valid  = 1'b1;
            m_rxdata = b;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic model_w1c(input logic [3:0] m);
        if (m[1]) m_valid   = 1'b0;
        if (m[2]) m_overrun = 1'b0;
        if (m[3]) m_ferr    = 1'b0;
    endtask

    task automatic check_rx(input string tag);
        logic [31:0] rd;
        bus_read({24'h0, UART_STATUS}, rd);
        check_eq({tag, "_status"}, rd, {28'h0, m_ferr, m_overrun, m_valid, 1'b0});
        bus_read({24'h0, UART_RXDATA}, rd);
        check_eq({tag, "_rxdata"}, rd, {24'h0, m_rxdata});
        check_eq({tag, "_irq"}, 32'(irq), 32'(m_valid & m_ctrl[2]));
    endtask

    // Drives one 8N1 frame; the bit period is counted in clk cycles.
    task automatic send_frame(input logic [7:0] b, input int div, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_line = f[i];
            repeat (div) begin
                @(posedge clk);
                #1;
            end
        end
        rx_line = 1'b1;
    endtask

    // Checks the tx waveform cycle by cycle and counts busy cycles via STATUS reads.
    // With drop set, a TXDATA write lands mid-frame; its read slot returns 0.
    task automatic tx_frame(input logic [7:0] b, input bit drop);
        int         div;
        int         busy_cnt;
        logic [9:0] f;
        div      = div_of(m_baud);
        f        = {1'b1, b, 1'b0};
        busy_cnt = 0;
        bus_write({24'h0, UART_TXDATA}, {24'h0, b});
        bus.addr_i = {24'h0, UART_STATUS};
        for (int k = 0; k <= 10 * div + 1; k++) begin
            if (k < 10 * div) begin
                check_eq($sformatf("tx_b%02h_bit%0d_k%0d", b, k / div, k), 32'(tx_line),
                         32'(f[k / div]));
            end else begin
                check_eq($sformatf("tx_b%02h_idle_k%0d", b, k), 32'(tx_line), 32'd1);
            end
            if (!(drop && k == 5)) busy_cnt += int'(bus.data_o[0]);
            if (drop && k == 4) begin
                bus.addr_i = {24'h0, UART_TXDATA};
                bus.data_i = 32'h3C;
                bus.we_i   = 1'b1;
            end
            if (drop && k == 5) begin
                bus.addr_i = {24'h0, UART_STATUS};
                bus.we_i   = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        check_eq($sformatf("tx_b%02h_busy_cycles", b), 32'(busy_cnt),
                 32'(drop ? 10 * div - 1 : 10 * div));
    endtask

    initial begin
        logic [31:0] rd;
        logic [15:0] bauds [6];
        logic [7:0]  b;
        logic        good;
        logic [3:0]  mask;

        bauds = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7};
        rst        = 1'b1;
        rx_line    = 1'b1;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.we_i   = 1'b0;
        m_baud     = 16'd434;
        m_ctrl     = '0;
        m_valid    = 1'b0;
        m_overrun  = 1'b0;
        m_ferr     = 1'b0;
        m_rxdata   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_data_o", bus.data_o, 32'd0);
        check_eq("rst_tx", 32'(tx_line), 32'd1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        rst = 1'b0;

        bus_read({24'h0, UART_BAUD}, rd);   check_eq("rst_baud", rd, 32'd434);
        bus_read({24'h0, UART_STATUS}, rd); check_eq("rst_status", rd, 32'd0);
        bus_read({24'h0, UART_CTRL}, rd);   check_eq("rst_ctrl", rd, 32'd0);
        bus_read({24'h0, UART_RXDATA}, rd); check_eq("rst_rxdata", rd, 32'd0);
        bus_read(32'h1C, rd);               check_eq("unmapped_1c", rd, 32'd0);
        bus_read(32'h108, rd);              check_eq("alias_108", rd, 32'd434);
        bus_read({24'h0, UART_TXDATA}, rd); check_eq("txdata_reads0", rd, 32'd0);

        // Same-cycle read and write returns the old value.
        bus_write({24'h0, UART_BAUD}, 32'd4);
        check_eq("rw_same_cycle", bus.data_o, 32'd434);
        m_baud = 16'd4;
        bus_read({24'h0, UART_BAUD}, rd);   check_eq("baud_wr", rd, 32'd4);

        // TX disabled: a TXDATA write must not start a frame.
        bus_write({24'h0, UART_TXDATA}, 32'h00);
        idle_cycles(2);
        check_eq("tx_disabled", 32'(tx_line), 32'd1);

        bus_write({24'h0, UART_CTRL}, 32'd1);
        m_ctrl = 3'd1;
        tx_frame(8'hA5, 1'b1);

        for (int i = 0; i < 6; i++) begin
            m_baud = (i == 0) ? 16'd1 : bauds[$urandom_range(0, 5)];
            bus_write({24'h0, UART_BAUD}, {16'h0, m_baud});
            tx_frame(8'($urandom), 1'b0);
        end

        // RX directed cases at BAUD=4.
        bus_write({24'h0, UART_BAUD}, 32'd4);
        m_baud = 16'd4;
        bus_write({24'h0, UART_CTRL}, 32'd6);
        m_ctrl = 3'd6;
        send_frame(8'h5A, 4, 1'b1);
        model_frame(8'h5A, 1'b1);
        idle_cycles(8);
        check_rx("rx_5a");
        bus_write({24'h0, UART_STATUS}, 32'h2);
        model_w1c(4'h2);
        check_eq("irq_clear", 32'(irq), 32'd0);

        send_frame(8'h11, 4, 1'b1); model_frame(8'h11, 1'b1); idle_cycles(8);
        send_frame(8'h22, 4, 1'b1); model_frame(8'h22, 1'b1); idle_cycles(8);
        check_rx("overrun");
        send_frame(8'h33, 4, 1'b0); model_frame(8'h33, 1'b0); idle_cycles(8);
        check_rx("frame_err");
        bus_write({24'h0, UART_STATUS}, 32'hE);
        model_w1c(4'hE);

        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, 4, good);
            model_frame(b, good);
            idle_cycles(8);
            check_rx($sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) begin
                mask = 4'($urandom_range(0, 15));
                bus_write({24'h0, UART_STATUS}, {28'h0, mask});
                model_w1c(mask);
            end
        end

        // One-cycle glitch at BAUD=8 is rejected; the following frame is clean.
        bus_write({24'h0, UART_BAUD}, 32'd8);
        m_baud = 16'd8;
        bus_write({24'h0, UART_STATUS}, 32'hE);
        model_w1c(4'hE);
        rx_line = 1'b0;
        idle_cycles(1);
        rx_line = 1'b1;
        idle_cycles(20);
        check_rx("glitch");
        send_frame(8'h81, 8, 1'b1);
        model_frame(8'h81, 1'b1);
        idle_cycles(12);
        check_rx("after_glitch");

        // Asynchronous reset in the middle of a TX frame with irq pending.
        bus_write({24'h0, UART_CTRL}, 32'd7);
        m_ctrl = 3'd7;
        check_eq("irq_pre_rst", 32'(irq), 32'd1);
        bus_write({24'h0, UART_TXDATA}, 32'h00);
        idle_cycles(3);
        check_eq("tx_pre_rst", 32'(tx_line), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx_line), 32'd1);
        check_eq("midrst_irq", 32'(irq), 32'd0);
        check_eq("midrst_data_o", bus.data_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_read({24'h0, UART_BAUD}, rd);   check_eq("postrst_baud", rd, 32'd434);
        bus_read({24'h0, UART_STATUS}, rd); check_eq("postrst_status", rd, 32'd0);
        check_eq("postrst_tx", 32'(tx_line), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_slave.md
Name: uart_slave

Overview:
Memory-mapped 8N1 UART peripheral attached to one slave port of the RIB bus (slave 3, address region 0x3xxx_xxxx).
- Interface: addr/wdata/we from the bus; returns registered read data one cycle after the address is presented, matching the bus's registered read-return select for master 0.
- Contains an independent TX shifter, an RX oversampling receiver, a baud divisor and a status/interrupt register.
- Reads have no side effects, because the bus drives slave address 0 when the slave is not granted.

Parameters:
DEFAULT_DIV, 16'd434, reset value of BAUD (50 MHz / 115200); clock cycles per bit.
ADDR_BITS, 8, low address bits decoded; upper bits ignored, so the register map aliases.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
addr_i  in  CPU_WIDTH  byte address from bus (top nibble already zeroed).
data_i  in  CPU_WIDTH  write data.
we_i  in  1  write strobe; a write occurs on each clk edge where we_i=1.
data_o  out  CPU_WIDTH  registered read data for the address of the previous cycle.
tx_o  out  1  serial transmit line, idle high.
rx_i  in  1  serial receive line, asynchronous to clk.
irq_o  out  1  level interrupt, = rx_valid & CTRL.rx_irq_en.

Behaviour:
- Register map, decoded on addr_i[7:0]. Unmapped offsets read 0; writes to them are ignored.
  - 0x00 CTRL (RW): bit0 tx_en, bit1 rx_en, bit2 rx_irq_en. Reset 0.
  - 0x04 STATUS: bit0 tx_busy (RO), bit1 rx_valid (W1C), bit2 rx_overrun (W1C), bit3 rx_frame_err (W1C). Reset 0.
  - 0x08 BAUD (RW): bits[15:0] divisor. Reset DEFAULT_DIV. Stored values below 2 operate as 2.
  - 0x0C TXDATA (WO, reads 0): a write with tx_en=1 and tx_busy=0 starts a frame. Any other write is dropped with no error flag.
  - 0x10 RXDATA (RO): bits[7:0] last good byte. Reset 0.
- Read path: data_o <= mux(addr_i) every cycle, so latency is 1 cycle. Reset value of data_o is 0.
- Same-cycle read and write to a register: data_o returns the pre-write value.
- Divisor latch: each FSM latches the divisor at frame start. BAUD writes mid-frame affect only the next frame.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - START drives tx_o=0 for div cycles.
  - DATA shifts 8 bits LSB first, div cycles each.
  - STOP drives tx_o=1 for div cycles.
  - tx_busy=1 from the cycle after the accepted TXDATA write until STOP completes. The next frame can begin the following cycle.
  - Clearing tx_en mid-frame does not abort the current frame.
- RX path: rx_i passes through a 2-flop synchronizer with reset value 1.
- RX FSM, only while rx_en=1: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: a falling edge of the synchronized line enters START.
  - START: waits div/2 (integer floor) cycles, then resamples. If the line is high (glitch), return to IDLE with no flags.
  - DATA: samples every div cycles, 8 bits LSB first.
  - STOP: sampled after a further div cycles.
  - Stop bit = 1: RXDATA is updated and rx_valid set. If rx_valid was already 1, rx_overrun is also set; new data overwrites.
  - Stop bit = 0: rx_frame_err is set, RXDATA and rx_valid are unchanged.
  - Clearing rx_en mid-frame returns RX to IDLE immediately; flags are kept.
- Simultaneous events: hardware set wins over a W1C clear in the same cycle.
- Reset mid-operation: all state clears asynchronously; tx_o=1, irq_o=0, both FSMs go to IDLE, BAUD=DEFAULT_DIV.

Decomposition:
- UART register offsets (UART_CTRL/STATUS/BAUD/TXDATA/RXDATA) and STATUS bit positions are added to rooth_defines.v.
- The UART slave index is added alongside the bus slave constants.
- One sub-module, uart_rx: synchronizer plus RX FSM. Outputs are a byte, a valid pulse and a frame-error pulse.
- TX FSM, register file and read mux stay in uart_slave.

Test Plan:
- Reset: assert rst mid-TX-frame -> tx_o=1 within the same cycle; a read of 0x08 returns 434; STATUS reads 0; irq_o=0.
- TX at BAUD=4, CTRL=1, write TXDATA=0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1 with each bit held 4 cycles.
  - tx_busy is 1 for 40 cycles.
  - A second write of 0x3C during the frame is dropped.
- RX at BAUD=4, CTRL=6, drive 0x5A frame on rx_i -> RXDATA=0x5A, STATUS=0x2, irq_o=1.
  - Writing STATUS=0x2 clears irq_o the next cycle.
- Overrun and frame error, BAUD=4:
  - Two good frames without a clear -> STATUS=0x6 and RXDATA holds the second byte.
  - A frame with stop bit 0 -> bit3 set, RXDATA unchanged.
- Glitch: rx_i low for 1 cycle at BAUD=8 -> no flags set, RX back in IDLE, the next valid frame 0x81 is received correctly.
- Read latency and decode:
  - addr 0x08 in cycle n -> data_o=BAUD in cycle n+1.
  - addr 0x1C -> data_o=0.
  - addr 0x108 aliases to BAUD.
  - BAUD=1 behaves as 2-cycle bits.
